// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked WIDTH-bit ALU with iterative MUL (ALU_MUL_EN) and DIV
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic [WIDTH:0]   add_w, sub_w, div_trial;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_c, sc_v, sc_dz;
    logic             accept, mul_start, iter_start;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic           is_div;
    logic [WIDTH:0] mul_sum;
    assign mul_start = (op == OP_MUL);
    assign mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
`else
    assign mul_start = 1'b0;
`endif
    assign iter_start = mul_start || ((op == OP_DIV) && (b != '0));

    assign add_w     = {1'b0, a} + {1'b0, b};
    assign sub_w     = {1'b0, a} - {1'b0, b};
    // Restoring step: a set top bit means the trial subtraction went negative.
    assign div_trial = {hi, lo[WIDTH-1]} - {1'b0, opnd};

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
            OP_SHL: begin
                sc_res = {a[WIDTH-2:0], 1'b0};
                sc_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_ROL:  sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  sc_res = {a[0], a[WIDTH-1:1]};
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NAND: sc_res = ~(a & b);
            OP_NOR:  sc_res = ~(a | b);
            OP_XNOR: sc_res = ~(a ^ b);
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        hi_nx = hi;
        lo_nx = lo;
`ifdef ALU_MUL_EN
        if (!is_div) begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
        end else
`endif
        if (div_trial[WIDTH]) begin
            hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_nx = {lo[WIDTH-2:0], 1'b0};
        end else begin
            hi_nx = div_trial[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
`ifdef ALU_MUL_EN
            is_div    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (iter_start) begin
                            state <= S_BUSY;
                            cnt   <= '0;
                            hi    <= '0;
                            lo    <= mul_start ? b : a;
                            opnd  <= mul_start ? a : b;
`ifdef ALU_MUL_EN
                            is_div <= !mul_start;
`endif
                        end else begin
                            state     <= S_DONE;
                            result    <= sc_res;
                            result_hi <= sc_hi;
                            flags     <= {sc_dz, sc_v, sc_c, (sc_res == '0)};
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        result    <= lo_nx;
                        result_hi <= hi_nx;
                        flags     <= {3'b000, (lo_nx == '0)};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - self-checking bench for alu_seq_param (WIDTH=8)
module tb_alu_seq_param;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result, result_hi;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, res, hi;
        logic [3:0] fl;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] res, hi;
        logic [3:0] fl;
        int         lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   lat;
        int   guard;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = v.op;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.res = v.res; e.hi = v.hi; e.fl = v.fl; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = ~v.op;
        a  = ~v.a;
        b  = ~v.b;
        lat = 1;
        while (!out_valid && lat < 50) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("result", 32'(result), 32'(e.res));
        chk("result_hi", 32'(result_hi), 32'(e.hi));
        chk("flags", 32'(flags), 32'(e.fl));
        chk("latency", 32'(lat), 32'(e.lat));
    endtask

    initial begin
        vecs.push_back('{4'b0000, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1});
        vecs.push_back('{4'b0000, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0100, 1});
        vecs.push_back('{4'b0001, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b0010, 1});
        vecs.push_back('{4'b0001, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1});
`ifdef ALU_MUL_EN
        vecs.push_back('{4'b0010, 8'd200, 8'd3, 8'h58, 8'h02, 4'b0000, 9});
        vecs.push_back('{4'b0010, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0000, 9});
`else
        vecs.push_back('{4'b0010, 8'd5, 8'd5, 8'h00, 8'h00, 4'b0001, 1});
        vecs.push_back('{4'b0010, 8'd200, 8'd3, 8'h00, 8'h00, 4'b0001, 1});
`endif
        vecs.push_back('{4'b0011, 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, 9});
        vecs.push_back('{4'b0011, 8'd3, 8'd10, 8'd0, 8'd3, 4'b0001, 9});
        vecs.push_back('{4'b0011, 8'd100, 8'd0, 8'hFF, 8'd100, 4'b1000, 1});
        vecs.push_back('{4'b0100, 8'h81, 8'h00, 8'h02, 8'h00, 4'b0010, 1});
        vecs.push_back('{4'b0100, 8'h80, 8'h00, 8'h00, 8'h00, 4'b0011, 1});
        vecs.push_back('{4'b0101, 8'h81, 8'h00, 8'h40, 8'h00, 4'b0010, 1});
        vecs.push_back('{4'b0110, 8'h81, 8'h00, 8'h03, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b0111, 8'h81, 8'h00, 8'hC0, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1000, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1001, 8'hF0, 8'h3C, 8'hFC, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1010, 8'hF0, 8'h3C, 8'hCC, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1011, 8'hF0, 8'h3C, 8'hCF, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1100, 8'hF0, 8'h3C, 8'h03, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1101, 8'hF0, 8'h3C, 8'h33, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1110, 8'h05, 8'h03, 8'h01, 8'h00, 4'b0000, 1});
        vecs.push_back('{4'b1110, 8'h03, 8'h05, 8'h00, 8'h00, 4'b0001, 1});
        vecs.push_back('{4'b1111, 8'h5A, 8'h5A, 8'h01, 8'h00, 4'b0000, 1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // Backpressure on ROL, then release together with a new request.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 4'b0110; a = 8'h81; b = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out_valid_first", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_result", 32'(result), 32'h03);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 4'b0000; a = 8'd4; b = 8'd5;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_result", 32'(result), 32'h03);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(result), 32'd9);
        chk("b2b_flags", 32'(flags), 32'd0);

        // Reset in the middle of a DIV.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 4'b0011; a = 8'd100; b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_result_hi", 32'(result_hi), 32'd0);
        chk("mid_rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op('{4'b0000, 8'h12, 8'h34, 8'h46, 8'h00, 4'b0000, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
